// File: rtl/uart_tx_arb.sv
// ============================================================================
// Module   : uart_tx_arb
// Brief    : Round-robin packet arbiter feeding a UART TX FIFO, optional
//            channel-ID header byte and mid-packet idle timeout abort.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_tx_arb #(
    parameter int unsigned P_REQ_CNT = 4,
    parameter int unsigned P_BIT_CNT = 8,
    parameter int unsigned P_HDR_EN  = 1,
    parameter int unsigned P_TIMEOUT = 1024
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic [P_REQ_CNT-1:0]           i_req_valid,
    input  logic [P_REQ_CNT*P_BIT_CNT-1:0] i_req_data,
    input  logic [P_REQ_CNT-1:0]           i_req_last,
    output logic [P_REQ_CNT-1:0]           o_req_ready,
    output logic [P_BIT_CNT-1:0]           o_fifo_wr_data,
    output logic                           o_fifo_wr_en,
    input  logic                           i_fifo_full,
    output logic [P_REQ_CNT-1:0]           o_grant,
    output logic                           o_abort
);

    localparam int unsigned c_ptr_w = $clog2(P_REQ_CNT);
    localparam int unsigned c_cnt_w = $clog2(P_TIMEOUT) + 1;
    localparam logic [c_cnt_w-1:0] c_to_last =
        (P_TIMEOUT == 0) ? '0 : c_cnt_w'(P_TIMEOUT - 1);
    localparam logic [P_BIT_CNT-1:0] c_hdr_msb = {1'b1, {(P_BIT_CNT-1){1'b0}}};
    localparam logic [P_REQ_CNT-1:0] c_one     = {{(P_REQ_CNT-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        s_idle = 2'd0,
        s_hdr  = 2'd1,
        s_data = 2'd2
    } state_t;

    state_t               r_state;
    logic [P_REQ_CNT-1:0] r_grant;
    logic [c_ptr_w-1:0]   r_owner;
    logic [c_ptr_w-1:0]   r_ptr;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_abort;

    logic                 w_found;
    logic [c_ptr_w-1:0]   w_pick;
    logic [c_ptr_w-1:0]   w_next_ptr;
    logic                 w_xfer;
    logic                 w_timeout;
    logic [P_BIT_CNT-1:0] w_hdr;
    logic [P_BIT_CNT-1:0] w_owner_data;

    function automatic logic [c_ptr_w-1:0] f_wrap(input int v);
        return (v >= int'(P_REQ_CNT)) ? c_ptr_w'(v - int'(P_REQ_CNT)) : c_ptr_w'(v);
    endfunction

    // Scan offsets high to low so the smallest offset from the pointer wins.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_ptr;
        for (int i = int'(P_REQ_CNT) - 1; i >= 0; i--) begin
            if (i_req_valid[f_wrap(int'(r_ptr) + i)]) begin
                w_found = 1'b1;
                w_pick  = f_wrap(int'(r_ptr) + i);
            end
        end
    end

    assign w_next_ptr   = f_wrap(int'(r_owner) + 1);
    assign w_owner_data = i_req_data[int'(r_owner)*P_BIT_CNT +: P_BIT_CNT];
    assign w_hdr        = c_hdr_msb | P_BIT_CNT'(r_owner);
    assign w_xfer       = (r_state == s_data) && i_req_valid[r_owner] && !i_fifo_full;
    // A full FIFO freezes the idle count, so only requester silence can abort.
    assign w_timeout    = (P_TIMEOUT != 0) && (r_state == s_data) && !i_fifo_full &&
                          !w_xfer && (r_cnt == c_to_last);

    always_comb begin
        o_req_ready    = '0;
        o_fifo_wr_en   = 1'b0;
        o_fifo_wr_data = '0;
        case (r_state)
            s_hdr: begin
                o_fifo_wr_en   = !i_fifo_full;
                o_fifo_wr_data = w_hdr;
            end
            s_data: begin
                o_req_ready[r_owner] = !i_fifo_full;
                o_fifo_wr_en         = w_xfer;
                o_fifo_wr_data       = w_owner_data;
            end
            default: ;
        endcase
    end

    assign o_grant = r_grant;
    assign o_abort = r_abort;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= s_idle;
            r_grant <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_abort <= 1'b0;
        end else begin
            r_abort <= 1'b0;
            case (r_state)
                s_idle: begin
                    if (w_found) begin
                        r_grant <= c_one << w_pick;
                        r_owner <= w_pick;
                        r_cnt   <= '0;
                        r_state <= (P_HDR_EN != 0) ? s_hdr : s_data;
                    end
                end
                s_hdr: begin
                    if (!i_fifo_full) begin
                        r_cnt   <= '0;
                        r_state <= s_data;
                    end
                end
                s_data: begin
                    if (w_xfer) begin
                        r_cnt <= '0;
                        if (i_req_last[r_owner]) begin
                            r_state <= s_idle;
                            r_grant <= '0;
                            r_ptr   <= w_next_ptr;
                        end
                    end else if (w_timeout) begin
                        r_cnt   <= '0;
                        r_state <= s_idle;
                        r_grant <= '0;
                        r_ptr   <= w_next_ptr;
                        r_abort <= 1'b1;
                    end else if (!i_fifo_full && (P_TIMEOUT != 0)) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= s_idle;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
// ============================================================================
// Module   : tb_uart_tx_arb
// Brief    : Directed bench for uart_tx_arb (header/timeout instance and a
//            header-less instance sharing clock and reset).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_tx_arb;

    logic        clk;
    logic        rst;

    logic [3:0]  a_valid, a_last, a_ready, a_grant;
    logic [31:0] a_data;
    logic [7:0]  a_wr_data;
    logic        a_wr_en, a_full, a_abort;

    logic [3:0]  b_valid, b_last, b_ready, b_grant;
    logic [31:0] b_data;
    logic [7:0]  b_wr_data;
    logic        b_wr_en, b_full, b_abort;

    logic [7:0]  qa[$];
    logic [7:0]  qb[$];
    int          a_aborts;
    int          checks;
    int          errors;

    logic [7:0]  c_t1 [4]  = '{8'h80, 8'h11, 8'h22, 8'h33};
    logic [7:0]  c_t2 [10] = '{8'h80, 8'h10, 8'h81, 8'h11, 8'h82, 8'h12,
                               8'h83, 8'h13, 8'h80, 8'h10};
    logic [7:0]  c_t3 [4]  = '{8'h81, 8'hA1, 8'hA2, 8'hA3};
    logic [7:0]  c_t4 [4]  = '{8'h82, 8'h5A, 8'h83, 8'hD3};
    logic [7:0]  c_t6 [3]  = '{8'hB1, 8'hB2, 8'hC1};

    uart_tx_arb #(.P_REQ_CNT(4), .P_BIT_CNT(8), .P_HDR_EN(1), .P_TIMEOUT(8)) u_dut_a (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (a_valid),
        .i_req_data     (a_data),
        .i_req_last     (a_last),
        .o_req_ready    (a_ready),
        .o_fifo_wr_data (a_wr_data),
        .o_fifo_wr_en   (a_wr_en),
        .i_fifo_full    (a_full),
        .o_grant        (a_grant),
        .o_abort        (a_abort)
    );

    uart_tx_arb #(.P_REQ_CNT(4), .P_BIT_CNT(8), .P_HDR_EN(0), .P_TIMEOUT(0)) u_dut_b (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (b_valid),
        .i_req_data     (b_data),
        .i_req_last     (b_last),
        .o_req_ready    (b_ready),
        .o_fifo_wr_data (b_wr_data),
        .o_fifo_wr_en   (b_wr_en),
        .i_fifo_full    (b_full),
        .o_grant        (b_grant),
        .o_abort        (b_abort)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // FIFO-side capture between edges, while inputs are stable.
    always @(negedge clk) begin
        if (rst) begin
            qa.delete();
            qb.delete();
            a_aborts = 0;
        end else begin
            if (a_wr_en) qa.push_back(a_wr_data);
            if (b_wr_en) qb.push_back(b_wr_data);
            if (a_abort) a_aborts++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_qa(input string tag, input int idx, input logic [7:0] exp);
        logic [7:0] v;
        v = (idx < qa.size()) ? qa[idx] : 8'hxx;
        chk($sformatf("%s[%0d]", tag, idx), {24'h0, v}, {24'h0, exp});
    endtask

    task automatic chk_qb(input string tag, input int idx, input logic [7:0] exp);
        logic [7:0] v;
        v = (idx < qb.size()) ? qb[idx] : 8'hxx;
        chk($sformatf("%s[%0d]", tag, idx), {24'h0, v}, {24'h0, exp});
    endtask

    task automatic do_reset();
        a_valid = '0; a_last = '0; a_data = '0; a_full = 1'b0;
        b_valid = '0; b_last = '0; b_data = '0; b_full = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        a_aborts = 0;
        rst      = 1'b1;
        a_valid = '0; a_last = '0; a_data = '0; a_full = 1'b0;
        b_valid = '0; b_last = '0; b_data = '0; b_full = 1'b0;
        tick();
        tick();
        chk("rst_grant", {28'h0, a_grant}, 32'h0);
        chk("rst_wr_en", {31'h0, a_wr_en}, 32'h0);
        chk("rst_ready", {28'h0, a_ready}, 32'h0);
        chk("rst_abort", {31'h0, a_abort}, 32'h0);
        rst = 1'b0;

        // Req0: 11,22,33 with header.
        tick();
        a_valid = 4'b0001; a_data[7:0] = 8'h11;
        #1;
        chk("t1_idle_grant", {28'h0, a_grant}, 32'h0);
        chk("t1_idle_wr_en", {31'h0, a_wr_en}, 32'h0);
        chk("t1_idle_ready", {28'h0, a_ready}, 32'h0);
        tick();
        chk("t1_grant", {28'h0, a_grant}, 32'h1);
        chk("t1_hdr_en", {31'h0, a_wr_en}, 32'h1);
        chk("t1_hdr_data", {24'h0, a_wr_data}, 32'h80);
        chk("t1_hdr_ready", {28'h0, a_ready}, 32'h0);
        tick();
        chk("t1_data_ready", {28'h0, a_ready}, 32'h1);
        chk("t1_data0", {24'h0, a_wr_data}, 32'h11);
        tick();
        a_data[7:0] = 8'h22;
        tick();
        a_data[7:0] = 8'h33; a_last = 4'b0001;
        tick();
        a_valid = '0; a_last = '0;
        #1;
        chk("t1_end_grant", {28'h0, a_grant}, 32'h0);
        chk("t1_end_wr_en", {31'h0, a_wr_en}, 32'h0);
        chk("t1_qsize", qa.size(), 4);
        for (int i = 0; i < 4; i++) chk_qa("t1_q", i, c_t1[i]);

        // All four requesters, 1-byte packets: round robin from req0 and wrap.
        do_reset();
        a_valid = 4'b1111; a_last = 4'b1111; a_data = 32'h13121110;
        repeat (15) tick();
        a_valid = '0; a_last = '0;
        #1;
        chk("t2_qsize", qa.size(), 10);
        for (int i = 0; i < 10; i++) chk_qa("t2_q", i, c_t2[i]);

        // Req1 packet stalled by a full FIFO; non-owner req0 asserts last meanwhile.
        do_reset();
        a_valid = 4'b0010; a_data[15:8] = 8'hA1;
        tick();
        a_valid = 4'b0011; a_last = 4'b0001; a_data[7:0] = 8'h55;
        tick();
        a_full = 1'b1;
        #1;
        chk("t3_full_ready", {28'h0, a_ready}, 32'h0);
        chk("t3_full_wr_en", {31'h0, a_wr_en}, 32'h0);
        for (int i = 0; i < 9; i++) begin
            tick();
            chk("t3_stall_wr_en", {31'h0, a_wr_en}, 32'h0);
            chk("t3_stall_abort", {31'h0, a_abort}, 32'h0);
            chk("t3_stall_grant", {28'h0, a_grant}, 32'h2);
        end
        tick();
        a_full = 1'b0;
        #1;
        chk("t3_resume_ready", {28'h0, a_ready}, 32'h2);
        chk("t3_resume_data", {24'h0, a_wr_data}, 32'hA1);
        tick();
        a_data[15:8] = 8'hA2;
        tick();
        a_data[15:8] = 8'hA3; a_last = 4'b0011;
        tick();
        a_valid = '0; a_last = '0;
        #1;
        chk("t3_qsize", qa.size(), 4);
        for (int i = 0; i < 4; i++) chk_qa("t3_q", i, c_t3[i]);
        chk("t3_aborts", a_aborts, 0);

        // Req2 sends one byte then goes silent: abort after 8 idle cycles.
        do_reset();
        a_valid = 4'b0100; a_data[23:16] = 8'h5A;
        tick();
        tick();
        tick();
        a_valid = '0;
        repeat (7) tick();
        chk("t4_pre_abort", {31'h0, a_abort}, 32'h0);
        chk("t4_pre_grant", {28'h0, a_grant}, 32'h4);
        tick();
        chk("t4_abort", {31'h0, a_abort}, 32'h1);
        chk("t4_abort_grant", {28'h0, a_grant}, 32'h0);
        chk("t4_abort_wr_en", {31'h0, a_wr_en}, 32'h0);
        a_valid = 4'b1001; a_last = 4'b1001; a_data[7:0] = 8'h01; a_data[31:24] = 8'hD3;
        tick();
        chk("t4_abort_clear", {31'h0, a_abort}, 32'h0);
        chk("t4_next_grant", {28'h0, a_grant}, 32'h8);
        chk("t4_qsize", qa.size(), 2);
        tick();
        tick();
        a_valid = '0; a_last = '0;
        #1;
        for (int i = 0; i < 4; i++) chk_qa("t4_q", i, c_t4[i]);
        chk("t4_aborts", a_aborts, 1);

        // Reset mid-packet: outputs drop at once and the pointer restarts at 0.
        do_reset();
        a_valid = 4'b0100; a_last = 4'b0100; a_data[23:16] = 8'h77;
        tick();
        tick();
        tick();
        a_valid = 4'b0010; a_last = '0; a_data[15:8] = 8'h66;
        tick();
        chk("t5_grant", {28'h0, a_grant}, 32'h2);
        tick();
        tick();
        chk("t5_pre_wr_en", {31'h0, a_wr_en}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_wr_en", {31'h0, a_wr_en}, 32'h0);
        chk("t5_rst_ready", {28'h0, a_ready}, 32'h0);
        chk("t5_rst_grant", {28'h0, a_grant}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        a_valid = 4'b1111; a_last = 4'b1111;
        tick();
        chk("t5_after_grant", {28'h0, a_grant}, 32'h1);
        a_valid = '0; a_last = '0;

        // Header-less instance: two back-to-back req1 packets.
        do_reset();
        b_valid = 4'b0010; b_data[15:8] = 8'hB1;
        #1;
        chk("t6_idle_wr_en", {31'h0, b_wr_en}, 32'h0);
        tick();
        chk("t6_grant", {28'h0, b_grant}, 32'h2);
        chk("t6_wr_en", {31'h0, b_wr_en}, 32'h1);
        chk("t6_data0", {24'h0, b_wr_data}, 32'hB1);
        tick();
        b_data[15:8] = 8'hB2; b_last = 4'b0010;
        tick();
        b_data[15:8] = 8'hC1;
        #1;
        chk("t6_gap_wr_en", {31'h0, b_wr_en}, 32'h0);
        chk("t6_gap_grant", {28'h0, b_grant}, 32'h0);
        tick();
        chk("t6_regrant", {28'h0, b_grant}, 32'h2);
        chk("t6_c1", {24'h0, b_wr_data}, 32'hC1);
        tick();
        b_valid = '0; b_last = '0;
        #1;
        chk("t6_qsize", qb.size(), 3);
        for (int i = 0; i < 3; i++) chk_qb("t6_q", i, c_t6[i]);
        chk("t6_abort", {31'h0, b_abort}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
